// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one syn_FIFO write port among NUM_REQ producers.
// Bursts are capped at MAX_BURST writes. Define FIFO_ARB_STATS_EN to add the write and stall counters.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]         stat_writes,
  output logic [15:0]                   stat_stall,
`endif
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state;
  logic [IW-1:0]  owner, last_owner, base, sel;
  logic [BW-1:0]  burst_cnt;
  logic           any_req, found, wr, burst_end;
  int             idx;

  // Rotating priority scan: the slot after `base` goes first and `base` itself goes last.
  always_comb begin
    base    = (state == OWN) ? owner : last_owner;
    sel     = base;
    found   = 1'b0;
    idx     = 0;
    any_req = |req;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(base) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  // A synchronous reset still blocks the write in the cycle it is asserted.
  assign wr        = (state == OWN) && req[owner] && !fifo_full && !rst;
  assign burst_end = wr && (burst_cnt == BW'(MAX_BURST - 1));
  assign fifo_w_en = wr;
  assign busy      = (state != IDLE);

  always_comb begin
    ack = '0;
    if (wr) ack[owner] = 1'b1;
    fifo_w_data = '0;
    if (state == OWN && !rst)
      fifo_w_data = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      burst_cnt  <= '0;
      last_owner <= IW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (any_req) begin
          state     <= OWN;
          owner     <= sel;
          burst_cnt <= '0;
          grant     <= '0;
          grant[sel] <= 1'b1;
        end
        OWN: if (!req[owner] || burst_end) begin
          last_owner <= owner;
          burst_cnt  <= '0;
          grant      <= '0;
          if (any_req) begin
            owner      <= sel;
            grant[sel] <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end else if (wr) begin
          burst_cnt <= burst_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_writes <= '0;
      stat_stall  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (ack[i] && stat_writes[i*16 +: 16] != 16'hFFFF)
          stat_writes[i*16 +: 16] <= stat_writes[i*16 +: 16] + 16'd1;
      if (state == OWN && req[owner] && fifo_full && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter. Directed scenarios and random traffic are both checked every cycle against a
// transaction-level model that tracks the owner index, the burst count and the rotation pointer.
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, MB = 4;

  logic          clk = 0, rst = 1, fifo_full = 0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  grant, ack;
  logic          fifo_w_en, busy;
  logic [DW-1:0] fifo_w_data;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] stat_writes;
  logic [15:0]     stat_stall;
  int sw[N];
  int ss;
`endif

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .grant(grant), .ack(ack), .fifo_w_en(fifo_w_en), .fifo_w_data(fifo_w_data),
`ifdef FIFO_ARB_STATS_EN
    .stat_writes(stat_writes), .stat_stall(stat_stall),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int owner = -1, cnt = 0, last = N - 1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] r, int s);
    for (int i = 1; i <= N; i++) begin
      int j = (s + i) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Drive one cycle at negedge, check outputs, then advance the model to the next posedge.
  task automatic step(logic r_st, logic [N-1:0] r, logic [N*DW-1:0] d, logic f);
    logic ew;
    logic [N-1:0] eg, ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    rst = r_st; req = r; req_data = d; fifo_full = f;
    #1;
    ew = !r_st && owner >= 0 && r[owner] && !f;
    eg = '0; ea = '0; ed = '0;
    if (owner >= 0) eg[owner] = 1'b1;
    if (ew) ea[owner] = 1'b1;
    if (owner >= 0 && !r_st) ed = d[owner*DW +: DW];
    chk("grant", grant, eg);
    chk("busy", busy, owner >= 0);
    chk("w_en", fifo_w_en, ew);
    chk("ack", ack, ea);
    chk("w_data", fifo_w_data, ed);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk($sformatf("stat_writes%0d", i), stat_writes[i*16 +: 16], sw[i]);
    chk("stat_stall", stat_stall, ss);
    if (r_st) begin
      foreach (sw[i]) sw[i] = 0;
      ss = 0;
    end else begin
      if (ew && sw[owner] < 16'hFFFF) sw[owner]++;
      if (owner >= 0 && r[owner] && f && ss < 16'hFFFF) ss++;
    end
`endif
    if (r_st) begin
      owner = -1; cnt = 0; last = N - 1;
    end else if (owner < 0) begin
      if (r != 0) begin owner = pick(r, last); cnt = 0; end
    end else if (!r[owner] || (ew && cnt == MB - 1)) begin
      last = owner; cnt = 0;
      owner = (r != 0) ? pick(r, last) : -1;
    end else if (ew) begin
      cnt++;
    end
  endtask

  logic [N*DW-1:0] rr_data;
  int nwr;

  initial begin
`ifdef FIFO_ARB_STATS_EN
    foreach (sw[i]) sw[i] = 0;
    ss = 0;
`endif
    for (int i = 0; i < N; i++) rr_data[i*DW +: DW] = DW'(8'h10 + i);
    // Reset state, followed by a lone requester that should be re-granted without a gap.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    for (int k = 0; k < 14; k++) step(0, 4'b0001, 32'h05050505, 0);
    // Round robin: each requester should write its own data four times in turn.
    step(1, 0, 0, 0);
    nwr = 0;
    for (int k = 0; k < 34; k++) begin
      step(0, 4'b1111, rr_data, 0);
      if (fifo_w_en) begin
        chk("rr_seq", fifo_w_data, DW'(8'h10 + (nwr / MB) % N));
        nwr++;
      end
    end
    chk("rr_count", nwr, 33);
    // Back-pressure: requester 2 stalls after two writes, then finishes its burst.
    step(1, 0, 0, 0);
    step(0, 4'b0100, rr_data, 0); step(0, 4'b0100, rr_data, 0); step(0, 4'b0100, rr_data, 0);
    for (int k = 0; k < 3; k++) step(0, 4'b0100, rr_data, 1);
    for (int k = 0; k < 4; k++) step(0, 4'b0100, rr_data, 0);
    // Early release: requester 1 drops its request after one write while requester 3 is waiting.
    step(1, 0, 0, 0);
    step(0, 4'b1010, rr_data, 0); step(0, 4'b1010, rr_data, 0); step(0, 4'b1000, rr_data, 0);
    @(posedge clk); #1;
    chk("early_rel_grant", grant, 4'b1000);
    // Reset mid-burst, after which the rotation pointer should be restored.
    step(1, 0, 0, 0);
    step(0, 4'b0100, rr_data, 0); step(0, 4'b0100, rr_data, 0); step(0, 4'b0100, rr_data, 0);
    step(1, 4'b0100, rr_data, 0); step(0, 4'b1010, rr_data, 0);
    @(posedge clk); #1;
    chk("post_rst_grant", grant, 4'b0010);
    // Random traffic with mostly-held requests, occasional stalls and rare resets.
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] r;
      r = req;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      step($urandom_range(0, 150) == 0, r, {$urandom, $urandom}, $urandom_range(0, 3) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
